// File: rtl/tlu_fifo_write_arbiter_pkg.sv
// Shared word-format definitions for the TLU readout path: trigger words carry
// bit 31 set, FE words carry bit 31 clear. Host decoding uses the same package.
package tlu_fifo_write_arbiter_pkg;

    localparam int   FIFO_WORD_WIDTH    = 32;
    localparam int   TRIG_NUM_WIDTH     = 31;
    localparam int   TRIG_WORD_FLAG_BIT = 31;
    localparam logic TRIG_WORD_FLAG     = 1'b1;
    localparam logic FE_WORD_FLAG       = 1'b0;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_TRIG,
        GRANT_FE
    } grant_t;

    function automatic logic [FIFO_WORD_WIDTH-1:0] make_trig_word(
        input logic [TRIG_NUM_WIDTH-1:0] trig_num
    );
        return {TRIG_WORD_FLAG, trig_num};
    endfunction

    // The flag bit is forced even though FE data should already have it clear.
    function automatic logic [FIFO_WORD_WIDTH-1:0] make_fe_word(
        input logic [FIFO_WORD_WIDTH-1:0] fe_word
    );
        logic [FIFO_WORD_WIDTH-1:0] word;
        word                     = fe_word;
        word[TRIG_WORD_FLAG_BIT] = FE_WORD_FLAG;
        return word;
    endfunction

endpackage

// File: rtl/tlu_trig_word_buffer.sv
// Circular buffer holding trigger numbers until the shared FIFO can take them.
// A push into a full buffer is dropped; a same-cycle pop never makes room.
module tlu_trig_word_buffer
    import tlu_fifo_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = TRIG_NUM_WIDTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             BUS_CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        mem_q <= mem_d;
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tlu_fifo_write_arbiter.sv
// Merges buffered TLU trigger words and FE data words into one shared output
// FIFO; trigger words win and may use the headroom above the high-water mark.
module tlu_fifo_write_arbiter
    import tlu_fifo_write_arbiter_pkg::*;
#(
    parameter int TRIG_DEPTH     = 4,
    parameter int LOST_CNT_WIDTH = 8
) (
    input  logic                       BUS_CLK,
    input  logic                       RST,
    input  logic                       TRIG_DATA_VALID,
    input  logic [TRIG_NUM_WIDTH-1:0]  TRIG_DATA,
    output logic                       TRIG_DATA_ACK,
    input  logic                       FE_DATA_VALID,
    input  logic [FIFO_WORD_WIDTH-1:0] FE_DATA,
    output logic                       FE_DATA_READ,
    input  logic                       FIFO_FULL,
    input  logic                       FIFO_NEAR_FULL,
    output logic                       FIFO_WR,
    output logic [FIFO_WORD_WIDTH-1:0] FIFO_DATA,
    output logic                       TRIG_OVERFLOW,
    output logic [LOST_CNT_WIDTH-1:0]  LOST_COUNT
);

    localparam int CNT_W = $clog2(TRIG_DEPTH) + 1;

    grant_t                      grant;
    logic                        trig_push;
    logic                        trig_pop;
    logic                        trig_drop;
    logic                        trig_full;
    logic                        trig_empty;
    logic [CNT_W-1:0]            trig_count;
    logic [TRIG_NUM_WIDTH-1:0]   trig_pop_data;

    logic                        fifo_wr_q, fifo_wr_d;
    logic [FIFO_WORD_WIDTH-1:0]  fifo_data_q, fifo_data_d;
    logic                        trig_ack_q, trig_ack_d;
    logic                        overflow_q, overflow_d;
    logic [LOST_CNT_WIDTH-1:0]   lost_count_q, lost_count_d;

    assign trig_push = TRIG_DATA_VALID && !RST;
    assign trig_drop = trig_push && trig_full;
    assign trig_pop  = (grant == GRANT_TRIG);

    tlu_trig_word_buffer #(
        .DEPTH (TRIG_DEPTH),
        .WIDTH (TRIG_NUM_WIDTH)
    ) u_buf (
        .BUS_CLK   (BUS_CLK),
        .RST       (RST),
        .push      (trig_push),
        .push_data (TRIG_DATA),
        .pop       (trig_pop),
        .pop_data  (trig_pop_data),
        .full      (trig_full),
        .empty     (trig_empty),
        .count     (trig_count)
    );

    // FIFO_FULL is honoured in the grant cycle, so no write can land on a full FIFO.
    always_comb begin
        grant = GRANT_NONE;
        if (!RST && !FIFO_FULL) begin
            if (!trig_empty) begin
                grant = GRANT_TRIG;
            end else if (FE_DATA_VALID && !FIFO_NEAR_FULL) begin
                grant = GRANT_FE;
            end
        end
    end

    assign FE_DATA_READ = (grant == GRANT_FE);

    always_comb begin
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;
        trig_ack_d   = trig_push && !trig_full;
        overflow_d   = overflow_q || trig_drop;
        lost_count_d = lost_count_q;
        if (trig_drop && (lost_count_q != '1)) begin
            lost_count_d = lost_count_q + LOST_CNT_WIDTH'(1);
        end
        case (grant)
            GRANT_TRIG: begin
                fifo_wr_d   = 1'b1;
                fifo_data_d = make_trig_word(trig_pop_data);
            end
            GRANT_FE: begin
                fifo_wr_d   = 1'b1;
                fifo_data_d = make_fe_word(FE_DATA);
            end
            default: begin
                fifo_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
            trig_ack_q   <= 1'b0;
            overflow_q   <= 1'b0;
            lost_count_q <= '0;
        end else begin
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            trig_ack_q   <= trig_ack_d;
            overflow_q   <= overflow_d;
            lost_count_q <= lost_count_d;
        end
    end

    assign FIFO_WR       = fifo_wr_q;
    assign FIFO_DATA     = fifo_data_q;
    assign TRIG_DATA_ACK = trig_ack_q;
    assign TRIG_OVERFLOW = overflow_q;
    assign LOST_COUNT    = lost_count_q;

endmodule

// File: tb/tb_tlu_fifo_write_arbiter.sv
// Directed self-checking bench for tlu_fifo_write_arbiter with a small
// first-word-fall-through FE source model and a log of shared-FIFO writes.
module tb_tlu_fifo_write_arbiter;

    logic        BUS_CLK;
    logic        RST;
    logic        TRIG_DATA_VALID;
    logic [30:0] TRIG_DATA;
    logic        TRIG_DATA_ACK;
    logic        FE_DATA_VALID;
    logic [31:0] FE_DATA;
    logic        FE_DATA_READ;
    logic        FIFO_FULL;
    logic        FIFO_NEAR_FULL;
    logic        FIFO_WR;
    logic [31:0] FIFO_DATA;
    logic        TRIG_OVERFLOW;
    logic [7:0]  LOST_COUNT;

    int          n_asserts;
    int          n_fail;
    logic [31:0] fe_next;
    logic        fe_active;
    logic        fe_read_seen;
    logic [31:0] wr_log [$];
    int          ack_cnt;

    tlu_fifo_write_arbiter #(
        .TRIG_DEPTH     (4),
        .LOST_CNT_WIDTH (8)
    ) dut (
        .BUS_CLK         (BUS_CLK),
        .RST             (RST),
        .TRIG_DATA_VALID (TRIG_DATA_VALID),
        .TRIG_DATA       (TRIG_DATA),
        .TRIG_DATA_ACK   (TRIG_DATA_ACK),
        .FE_DATA_VALID   (FE_DATA_VALID),
        .FE_DATA         (FE_DATA),
        .FE_DATA_READ    (FE_DATA_READ),
        .FIFO_FULL       (FIFO_FULL),
        .FIFO_NEAR_FULL  (FIFO_NEAR_FULL),
        .FIFO_WR         (FIFO_WR),
        .FIFO_DATA       (FIFO_DATA),
        .TRIG_OVERFLOW   (TRIG_OVERFLOW),
        .LOST_COUNT      (LOST_COUNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    // One clock: sample the pop strobe before the edge, advance the FE model
    // and log any shared-FIFO write just after it.
    task automatic cycle();
        logic popped;
        #1;
        popped       = FE_DATA_READ;
        fe_read_seen = fe_read_seen | popped;
        @(posedge BUS_CLK);
        #1;
        if (popped) fe_next = fe_next + 32'd1;
        FE_DATA       = fe_next;
        FE_DATA_VALID = fe_active;
        if (FIFO_WR) wr_log.push_back(FIFO_DATA);
    endtask

    task automatic applyStimulus(input logic valid, input logic [30:0] data);
        TRIG_DATA_VALID = valid;
        TRIG_DATA       = data;
        cycle();
        TRIG_DATA_VALID = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] logEntry(input int idx);
        if (idx < wr_log.size()) return wr_log[idx];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic setFe(input logic active, input logic [31:0] first_word);
        fe_active     = active;
        fe_next       = first_word;
        FE_DATA       = first_word;
        FE_DATA_VALID = active;
    endtask

    initial begin
        n_asserts       = 0;
        n_fail          = 0;
        fe_read_seen    = 1'b0;
        RST             = 1'b1;
        TRIG_DATA_VALID = 1'b1;
        TRIG_DATA       = 31'h1234;
        FIFO_FULL       = 1'b0;
        FIFO_NEAR_FULL  = 1'b0;
        setFe(1'b1, 32'h0000_0099);

        // Reset with trigger and FE traffic present
        cycle();
        cycle();
        cycle();
        #1;
        checkOutput("rst_fifo_wr", 32'(FIFO_WR), 32'd0);
        checkOutput("rst_fifo_data", FIFO_DATA, 32'd0);
        checkOutput("rst_ack", 32'(TRIG_DATA_ACK), 32'd0);
        checkOutput("rst_overflow", 32'(TRIG_OVERFLOW), 32'd0);
        checkOutput("rst_lost", 32'(LOST_COUNT), 32'd0);
        checkOutput("rst_fe_read", 32'(FE_DATA_READ), 32'd0);
        RST             = 1'b0;
        TRIG_DATA_VALID = 1'b0;
        setFe(1'b0, 32'd0);
        cycle();
        checkOutput("rst_no_write", 32'(wr_log.size()), 32'd0);
        wr_log.delete();

        // Single trigger, FE idle
        applyStimulus(1'b1, 31'h0000_0005);
        checkOutput("single_ack", 32'(TRIG_DATA_ACK), 32'd1);
        checkOutput("single_wr_n1", 32'(FIFO_WR), 32'd0);
        cycle();
        checkOutput("single_wr_n2", 32'(FIFO_WR), 32'd1);
        checkOutput("single_data", FIFO_DATA, 32'h8000_0005);
        checkOutput("single_ack_low", 32'(TRIG_DATA_ACK), 32'd0);
        cycle();
        checkOutput("single_wr_idle", 32'(FIFO_WR), 32'd0);
        checkOutput("single_data_hold", FIFO_DATA, 32'h8000_0005);

        // Contention: continuous FE stream plus one trigger
        wr_log.delete();
        setFe(1'b1, 32'h0000_0001);
        cycle();
        cycle();
        cycle();
        applyStimulus(1'b1, 31'h7);
        checkOutput("cont_ack", 32'(TRIG_DATA_ACK), 32'd1);
        #1;
        checkOutput("cont_fe_paused", 32'(FE_DATA_READ), 32'd0);
        cycle();
        cycle();
        cycle();
        setFe(1'b0, fe_next);
        cycle();
        cycle();
        checkOutput("cont_len", 32'(wr_log.size()), 32'd7);
        checkOutput("cont_w0", logEntry(0), 32'h0000_0001);
        checkOutput("cont_w1", logEntry(1), 32'h0000_0002);
        checkOutput("cont_w2", logEntry(2), 32'h0000_0003);
        checkOutput("cont_w3", logEntry(3), 32'h0000_0004);
        checkOutput("cont_trig", logEntry(4), 32'h8000_0007);
        checkOutput("cont_w5", logEntry(5), 32'h0000_0005);
        checkOutput("cont_w6", logEntry(6), 32'h0000_0006);
        checkOutput("cont_fe_pops", fe_next, 32'd7);

        // Near-full: FE blocked, triggers still go out
        wr_log.delete();
        FIFO_NEAR_FULL = 1'b1;
        setFe(1'b1, 32'd100);
        fe_read_seen = 1'b0;
        applyStimulus(1'b1, 31'h11);
        checkOutput("nf_ack0", 32'(TRIG_DATA_ACK), 32'd1);
        applyStimulus(1'b1, 31'h22);
        checkOutput("nf_ack1", 32'(TRIG_DATA_ACK), 32'd1);
        cycle();
        cycle();
        cycle();
        checkOutput("nf_len", 32'(wr_log.size()), 32'd2);
        checkOutput("nf_t0", logEntry(0), 32'h8000_0011);
        checkOutput("nf_t1", logEntry(1), 32'h8000_0022);
        checkOutput("nf_fe_read", 32'(fe_read_seen), 32'd0);
        checkOutput("nf_fe_pops", fe_next, 32'd100);
        setFe(1'b0, 32'd0);
        FIFO_NEAR_FULL = 1'b0;

        // Overflow with FIFO_FULL held
        wr_log.delete();
        FIFO_FULL = 1'b1;
        ack_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 31'h21 + 31'(i));
            if (TRIG_DATA_ACK) ack_cnt++;
        end
        cycle();
        checkOutput("ovf_acks", 32'(ack_cnt), 32'd4);
        checkOutput("ovf_flag", 32'(TRIG_OVERFLOW), 32'd1);
        checkOutput("ovf_lost", 32'(LOST_COUNT), 32'd2);
        checkOutput("ovf_no_write", 32'(wr_log.size()), 32'd0);
        FIFO_FULL = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        checkOutput("ovf_len", 32'(wr_log.size()), 32'd4);
        checkOutput("ovf_t0", logEntry(0), 32'h8000_0021);
        checkOutput("ovf_t1", logEntry(1), 32'h8000_0022);
        checkOutput("ovf_t2", logEntry(2), 32'h8000_0023);
        checkOutput("ovf_t3", logEntry(3), 32'h8000_0024);
        checkOutput("ovf_idle_wr", 32'(FIFO_WR), 32'd0);
        checkOutput("ovf_data_hold", FIFO_DATA, 32'h8000_0024);
        checkOutput("ovf_sticky", 32'(TRIG_OVERFLOW), 32'd1);

        // Saturation of the lost counter
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        checkOutput("sat_rst_lost", 32'(LOST_COUNT), 32'd0);
        checkOutput("sat_rst_ovf", 32'(TRIG_OVERFLOW), 32'd0);
        FIFO_FULL = 1'b1;
        for (int i = 0; i < 258; i++) applyStimulus(1'b1, 31'(i));
        checkOutput("sat_254", 32'(LOST_COUNT), 32'd254);
        applyStimulus(1'b1, 31'h0);
        checkOutput("sat_255", 32'(LOST_COUNT), 32'd255);
        for (int i = 0; i < 45; i++) applyStimulus(1'b1, 31'h0);
        checkOutput("sat_hold", 32'(LOST_COUNT), 32'd255);

        // Mid-operation reset with 3 words pending
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 31'h31 + 31'(i));
        checkOutput("mid_ovf_pre", 32'(TRIG_OVERFLOW), 32'd1);
        checkOutput("mid_lost_pre", 32'(LOST_COUNT), 32'd1);
        wr_log.delete();
        FIFO_FULL = 1'b0;
        cycle();
        FIFO_FULL = 1'b1;
        checkOutput("mid_first_out", logEntry(0), 32'h8000_0031);
        checkOutput("mid_count_pre", 32'(dut.trig_count), 32'd3);
        wr_log.delete();
        RST             = 1'b1;
        FIFO_FULL       = 1'b0;
        TRIG_DATA_VALID = 1'b1;
        TRIG_DATA       = 31'h66;
        setFe(1'b1, 32'd500);
        cycle();
        cycle();
        checkOutput("mid_rst_ack", 32'(TRIG_DATA_ACK), 32'd0);
        RST             = 1'b0;
        TRIG_DATA_VALID = 1'b0;
        setFe(1'b0, fe_next);
        for (int i = 0; i < 4; i++) cycle();
        checkOutput("mid_no_write", 32'(wr_log.size()), 32'd0);
        checkOutput("mid_count", 32'(dut.trig_count), 32'd0);
        checkOutput("mid_ovf", 32'(TRIG_OVERFLOW), 32'd0);
        checkOutput("mid_lost", 32'(LOST_COUNT), 32'd0);
        checkOutput("mid_data", FIFO_DATA, 32'd0);
        checkOutput("mid_fe_pops", fe_next, 32'd500);
        applyStimulus(1'b1, 31'h55);
        checkOutput("post_ack", 32'(TRIG_DATA_ACK), 32'd1);
        cycle();
        checkOutput("post_wr", 32'(FIFO_WR), 32'd1);
        checkOutput("post_data", FIFO_DATA, 32'h8000_0055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/tlu_fifo_write_arbiter.md
TLU_FIFO_WRITE_ARBITER -- requirements
Module: tlu_fifo_write_arbiter

Interface
REQ-001 Parameter TRIG_DEPTH, default 4, depth of the pending trigger-word buffer; power of two, 2..16.
REQ-002 Parameter LOST_CNT_WIDTH, default 8, width of the saturating lost-trigger counter.
REQ-003 BUS_CLK  in  1  sole clock.
REQ-004 RST  in  1  reset, synchronous, active-high, clock BUS_CLK.
REQ-005 TRIG_DATA_VALID  in  1  one-cycle pulse; TRIG_DATA valid in the same cycle.
REQ-006 TRIG_DATA  in  31  TLU trigger number.
REQ-007 TRIG_DATA_ACK  out  1  one-cycle pulse; trigger word stored in the pending buffer.
REQ-008 FE_DATA_VALID  in  1  upstream first-word-fall-through FE FIFO is not empty.
REQ-009 FE_DATA  in  32  FE data word; bit 31 is 0 by contract.
REQ-010 FE_DATA_READ  out  1  combinational pop strobe to the FE FIFO.
REQ-011 FIFO_FULL  in  1  shared output FIFO full.
REQ-012 FIFO_NEAR_FULL  in  1  shared output FIFO above its high-water mark.
REQ-013 FIFO_WR  out  1  registered write strobe to the shared FIFO.
REQ-014 FIFO_DATA  out  32  registered write data.
REQ-015 TRIG_OVERFLOW  out  1  sticky flag; at least one trigger word was dropped.
REQ-016 LOST_COUNT  out  LOST_CNT_WIDTH  number of dropped trigger words, saturating.

Function
REQ-017 The pending buffer is a circular FIFO of TRIG_DEPTH 31-bit entries with a count register of width log2(TRIG_DEPTH)+1.
REQ-018 A TRIG_DATA_VALID with count < TRIG_DEPTH at the start of the cycle stores TRIG_DATA and drives TRIG_DATA_ACK high in the next cycle.
  - No lookahead: a pop in the same cycle does not make room.
REQ-019 A TRIG_DATA_VALID with a full buffer does the following:
  - drops the word;
  - produces no ACK;
  - sets TRIG_OVERFLOW next cycle;
  - increments LOST_COUNT, which holds at all-ones.
REQ-020 The grant is evaluated every cycle, one word at most per cycle, in this priority order:
  - a trigger word, when the buffer is non-empty and FIFO_FULL=0;
  - otherwise an FE word, when FE_DATA_VALID=1, FIFO_FULL=0 and FIFO_NEAR_FULL=0;
  - otherwise no grant.
REQ-021 FIFO_NEAR_FULL blocks only FE words; trigger words use the headroom above the high-water mark.
REQ-022 A trigger grant pops one entry. FIFO_DATA is {1'b1, entry[30:0]} in the next cycle, with FIFO_WR=1.
REQ-023 An FE grant asserts FE_DATA_READ in the grant cycle. FIFO_DATA is FE_DATA with bit 31 forced to 0 in the next cycle, with FIFO_WR=1.
REQ-024 With no grant, FIFO_WR is 0 in the next cycle and FIFO_DATA holds its previous value.
REQ-025 Trigger latency: TRIG_DATA_VALID in cycle n gives FIFO_WR in cycle n+2 at the earliest; the buffer has no bypass path.
REQ-026 A push and a pop in the same cycle leave the count unchanged; both pointers wrap modulo TRIG_DEPTH.
REQ-027 Trigger words leave in arrival order; FE words are never reordered.
REQ-028 FIFO_FULL is sampled combinationally in the grant cycle, so no write issues while FIFO_FULL=1.

Reset
REQ-029 While RST=1:
  - pointers and count clear, and the buffer becomes empty;
  - FIFO_WR, TRIG_DATA_ACK, TRIG_OVERFLOW and FE_DATA_READ are 0;
  - LOST_COUNT and FIFO_DATA are 0.
REQ-030 A RST asserted mid-operation discards pending trigger words without writing them and without counting them as lost.
REQ-031 TRIG_DATA_VALID is ignored in any cycle with RST=1.

Structure
REQ-032 A shared package holds TRIG_WORD_FLAG_BIT (31) and the trigger-word and FE-word format constants; the TLU readout and host decoding use the same package.
REQ-033 The pending buffer is a sub-module, tlu_trig_word_buffer, with push/pop/full/empty/count ports.
REQ-034 The arbiter grant logic and the output registers live in the top module.

Verification
REQ-035 Single trigger: TRIG_DATA=31'h0000_0005 pulse, FE idle -> ACK at n+1, FIFO_WR at n+2 with FIFO_DATA=32'h8000_0005.
REQ-036 Contention: FE_DATA_VALID=1 continuously (words 32'h0000_0001..) plus a trigger 31'h7 -> FE stream pauses exactly one cycle, 32'h8000_0007 is written, FE resumes with no FE word lost or duplicated.
REQ-037 Near-full: FIFO_NEAR_FULL=1, FE valid, 2 triggers -> FE_DATA_READ stays 0, both trigger words written in order, no FE writes.
REQ-038 Overflow: FIFO_FULL=1, 6 triggers, TRIG_DEPTH=4 -> 4 ACKs, TRIG_OVERFLOW=1, LOST_COUNT=2. Then release FIFO_FULL -> the 4 stored words are written in order.
REQ-039 Saturation: 300 drops with LOST_CNT_WIDTH=8 -> LOST_COUNT=255.
REQ-040 Mid-operation reset: 3 words pending, pulse RST -> no FIFO_WR afterwards, count=0, TRIG_OVERFLOW=0, LOST_COUNT=0. A new trigger afterwards is written normally.
